// File: rtl/register_window_manager_if.sv
// rtl/register_window_manager_if.sv - register-file and spill-memory transfer bus of the window manager
interface register_window_manager_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int RF_ADDR_WIDTH = 7
);
  logic [RF_ADDR_WIDTH-1:0] rfAddr_o;
  logic [DATA_WIDTH-1:0]    rfReadData_i;
  logic                     rfWriteEnable_o;
  logic [DATA_WIDTH-1:0]    rfWriteData_o;
  logic                     memReq_o;
  logic                     memWrite_o;
  logic [ADDR_WIDTH-1:0]    memAddr_o;
  logic [DATA_WIDTH-1:0]    memWriteData_o;
  logic                     memAck_i;
  logic [DATA_WIDTH-1:0]    memReadData_i;

  modport master (
    output rfAddr_o, rfWriteEnable_o, rfWriteData_o,
    output memReq_o, memWrite_o, memAddr_o, memWriteData_o,
    input  rfReadData_i, memAck_i, memReadData_i
  );

  modport slave (
    input  rfAddr_o, rfWriteEnable_o, rfWriteData_o,
    input  memReq_o, memWrite_o, memAddr_o, memWriteData_o,
    output rfReadData_i, memAck_i, memReadData_i
  );
endinterface

// File: rtl/register_window_manager.sv
// rtl/register_window_manager.sv - maps logical register windows onto physical banks, spilling/filling via memory
module register_window_manager #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    REGS_PER_BANK = 16,
  parameter int                    PHYS_BANKS    = 8,
  parameter int                    ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] SPILL_BASE    = 16'hF000
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          enable_i,
  input  logic [5:0]                    regBankSelect_i,
  output logic [$clog2(PHYS_BANKS)-1:0] physBank_o,
  output logic                          stall_o,
  output logic                          error_o,
  register_window_manager_if.master     bus
);
  localparam int PB_W = $clog2(PHYS_BANKS);
  localparam int RI_W = $clog2(REGS_PER_BANK);
  localparam int RC_W = PB_W + 1;

  typedef enum logic [2:0] {IDLE, SPILL_RD, SPILL_MEM, FILL_MEM, FILL_WR} state_t;

  state_t                 state_q, state_d;
  logic [5:0]             cur_bank_q, cur_bank_d;
  logic [5:0]             low_bank_q, low_bank_d;
  logic [5:0]             xfer_bank_q, xfer_bank_d;
  logic [RC_W-1:0]        res_count_q, res_count_d;
  logic [RI_W-1:0]        reg_idx_q, reg_idx_d;
  logic                   captured_q, captured_d;
  logic [DATA_WIDTH-1:0]  spill_data_q, spill_data_d;
  logic                   error_q, error_d;
  logic                   stall_q, stall_d;
  logic [PB_W+RI_W-1:0]   rf_addr_q, rf_addr_d;
  logic                   rf_we_q, rf_we_d;
  logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   last_reg;

  assign last_reg = (reg_idx_q == RI_W'(REGS_PER_BANK - 1));

  always_comb begin
    state_d      = state_q;
    cur_bank_d   = cur_bank_q;
    low_bank_d   = low_bank_q;
    xfer_bank_d  = xfer_bank_q;
    res_count_d  = res_count_q;
    reg_idx_d    = reg_idx_q;
    captured_d   = captured_q;
    spill_data_d = spill_data_q;
    error_d      = error_q;
    rf_wdata_d   = rf_wdata_q;

    case (state_q)
      IDLE: begin
        if (enable_i && (regBankSelect_i != cur_bank_q)) begin
          if (regBankSelect_i == cur_bank_q + 6'd1) begin
            cur_bank_d = cur_bank_q + 6'd1;
            if (res_count_q < RC_W'(PHYS_BANKS)) begin
              res_count_d = res_count_q + RC_W'(1);
            end else begin
              xfer_bank_d = low_bank_q;
              reg_idx_d   = '0;
              state_d     = SPILL_RD;
            end
          end else if (regBankSelect_i == cur_bank_q - 6'd1) begin
            cur_bank_d = cur_bank_q - 6'd1;
            // Last resident window left: refill the re-entered one, which becomes the only resident.
            if (res_count_q == RC_W'(1)) begin
              xfer_bank_d = cur_bank_q - 6'd1;
              low_bank_d  = cur_bank_q - 6'd1;
              reg_idx_d   = '0;
              state_d     = FILL_MEM;
            end else begin
              res_count_d = res_count_q - RC_W'(1);
            end
          end else begin
            error_d     = 1'b1;
            cur_bank_d  = regBankSelect_i;
            low_bank_d  = regBankSelect_i;
            res_count_d = RC_W'(1);
          end
        end
      end
      SPILL_RD: state_d = SPILL_MEM;
      SPILL_MEM: begin
        if (!captured_q) begin
          captured_d   = 1'b1;
          spill_data_d = bus.rfReadData_i;
        end
        if (bus.memAck_i) begin
          captured_d = 1'b0;
          if (last_reg) begin
            low_bank_d = low_bank_q + 6'd1;
            state_d    = IDLE;
          end else begin
            reg_idx_d = reg_idx_q + RI_W'(1);
            state_d   = SPILL_RD;
          end
        end
      end
      FILL_MEM: begin
        if (bus.memAck_i) begin
          rf_wdata_d = bus.memReadData_i;
          state_d    = FILL_WR;
        end
      end
      FILL_WR: begin
        if (last_reg) begin
          state_d = IDLE;
        end else begin
          reg_idx_d = reg_idx_q + RI_W'(1);
          state_d   = FILL_MEM;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    stall_d     = (state_d != IDLE);
    mem_req_d   = (state_d == SPILL_MEM) || (state_d == FILL_MEM);
    mem_write_d = (state_d == SPILL_MEM);
    mem_addr_d  = mem_req_d ? SPILL_BASE + ADDR_WIDTH'({xfer_bank_d, reg_idx_d}) : '0;
    rf_we_d     = (state_d == FILL_WR);
    rf_addr_d   = ((state_d == SPILL_RD) || (state_d == FILL_WR)) ?
                  {xfer_bank_d[PB_W-1:0], reg_idx_d} : '0;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      cur_bank_q   <= '0;
      low_bank_q   <= '0;
      xfer_bank_q  <= '0;
      res_count_q  <= RC_W'(1);
      reg_idx_q    <= '0;
      captured_q   <= 1'b0;
      spill_data_q <= '0;
      error_q      <= 1'b0;
      stall_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_we_q      <= 1'b0;
      rf_wdata_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_bank_q   <= cur_bank_d;
      low_bank_q   <= low_bank_d;
      xfer_bank_q  <= xfer_bank_d;
      res_count_q  <= res_count_d;
      reg_idx_q    <= reg_idx_d;
      captured_q   <= captured_d;
      spill_data_q <= spill_data_d;
      error_q      <= error_d;
      stall_q      <= stall_d;
      rf_addr_q    <= rf_addr_d;
      rf_we_q      <= rf_we_d;
      rf_wdata_q   <= rf_wdata_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign physBank_o          = cur_bank_q[PB_W-1:0];
  assign stall_o             = stall_q;
  assign error_o             = error_q;
  assign bus.rfAddr_o        = rf_addr_q;
  assign bus.rfWriteEnable_o = rf_we_q;
  assign bus.rfWriteData_o   = rf_wdata_q;
  assign bus.memReq_o        = mem_req_q;
  assign bus.memWrite_o      = mem_write_q;
  assign bus.memAddr_o       = mem_addr_q;
  // Register read data arrives in the first SPILL_MEM cycle; it is passed through then and held afterwards.
  assign bus.memWriteData_o  = !mem_write_q ? '0 : (captured_q ? spill_data_q : bus.rfReadData_i);
endmodule
